// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC generator with credit-limited fetch requests and in-order instruction queue
module fetch_pc_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter int unsigned     ILEN         = 32,
    parameter int unsigned     INST_BYTES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     DEPTH        = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_exe,
    input  logic [XLEN-1:0] redirect_exe_pc,
    input  logic            redirect_id,
    input  logic [XLEN-1:0] redirect_id_pc,
    output logic            if_req_valid,
    input  logic            if_req_ready,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_resp_valid,
    input  logic [ILEN-1:0] if_resp_inst,
    output logic [XLEN-1:0] pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic            busy
);
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   kill_cnt_q, kill_cnt_d;
    logic [CW-1:0]   qcount_q, qcount_d;

    logic [XLEN-1:0] tag_mem_q [DEPTH];
    logic [XLEN-1:0] tag_mem_d [DEPTH];
    logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [XLEN-1:0] q_pc_q [DEPTH];
    logic [XLEN-1:0] q_pc_d [DEPTH];
    logic [ILEN-1:0] q_inst_q [DEPTH];
    logic [ILEN-1:0] q_inst_d [DEPTH];
    logic [PW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [CW:0]     credits_used;
    logic            fire, resp_fire, resp_drop, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        redirect     = redirect_exe | redirect_id;
        target       = redirect_exe ? redirect_exe_pc : redirect_id_pc;
        // Killed-but-owed responses still hold a credit until they come back.
        credits_used = {1'b0, outstanding_q} + {1'b0, qcount_q};
        if_req_valid = ~rst & ~stall & ~redirect & (credits_used < CREDITS);
        fire         = if_req_valid & if_req_ready;
        resp_fire    = if_resp_valid & (outstanding_q != '0);
        resp_drop    = resp_fire & ((kill_cnt_q != '0) | redirect);
        push         = resp_fire & ~resp_drop;
        out_valid    = (qcount_q != '0);
        pop          = out_valid & ~stall & ~redirect;
    end

    assign if_req_addr = pc_q;
    assign pc          = pc_q;
    assign out_pc      = out_valid ? q_pc_q[q_rd_q] : '0;
    assign out_inst    = out_valid ? q_inst_q[q_rd_q] : '0;
    assign busy        = (outstanding_q != '0) | (kill_cnt_q != '0);

    always_comb begin
        pc_d          = pc_q;
        kill_cnt_d    = kill_cnt_q;
        tag_mem_d     = tag_mem_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        q_pc_d        = q_pc_q;
        q_inst_d      = q_inst_q;
        q_rd_d        = q_rd_q;
        q_wr_d        = q_wr_q;
        outstanding_d = outstanding_q + CW'(fire) - CW'(resp_fire);
        qcount_d      = qcount_q + CW'(push) - CW'(pop);

        if (fire) begin
            tag_mem_d[tag_wr_q] = pc_q;
            tag_wr_d            = ptr_inc(tag_wr_q);
            pc_d                = pc_q + XLEN'(INST_BYTES);
        end

        // Tags of killed requests were flushed, so only live responses pop the tag FIFO.
        if (resp_fire && kill_cnt_q == '0)
            tag_rd_d = ptr_inc(tag_rd_q);
        if (resp_fire && kill_cnt_q != '0)
            kill_cnt_d = kill_cnt_q - 1'b1;

        if (push) begin
            q_pc_d[q_wr_q]   = tag_mem_q[tag_rd_q];
            q_inst_d[q_wr_q] = if_resp_inst;
            q_wr_d           = ptr_inc(q_wr_q);
        end
        if (pop)
            q_rd_d = ptr_inc(q_rd_q);

        if (redirect) begin
            pc_d       = target;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            q_rd_d     = '0;
            q_wr_d     = '0;
            qcount_d   = '0;
            kill_cnt_d = outstanding_q - CW'(resp_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            qcount_q      <= '0;
            tag_mem_q     <= '{default: '0};
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            q_pc_q        <= '{default: '0};
            q_inst_q      <= '{default: '0};
            q_rd_q        <= '0;
            q_wr_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            qcount_q      <= qcount_d;
            tag_mem_q     <= tag_mem_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            q_pc_q        <= q_pc_d;
            q_inst_q      <= q_inst_d;
            q_rd_q        <= q_rd_d;
            q_wr_q        <= q_wr_d;
        end
    end
endmodule
